// File: rtl/eb_pkg.sv
// Shared constants and state type for the USB3 receive elastic-buffer write side.
package eb_pkg;

   localparam logic [9:0] COM_SYM = 10'h0FA;
   localparam logic [9:0] SKP_SYM = 10'h0F9;

   localparam int DEF_DEL_THRESH = 11;
   localparam int DEF_MAX_DEL    = 2;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      COM     = 2'd1,
      SKP_RUN = 2'd2
   } eb_os_state_t;

endpackage

// File: rtl/eb_wr_ctrl_if.sv
// Symbol input and buffer write port of the elastic-buffer write controller.
interface eb_wr_ctrl_if #(
   parameter int ADDR_W = 4
);
   logic [9:0]      sym_in;
   logic            sym_in_vld;
   logic [ADDR_W:0] fill_level;
   logic            eb_full;
   logic [9:0]      eb_data;
   logic            eb_wr_en;

   modport master (
      output sym_in, sym_in_vld, fill_level, eb_full,
      input  eb_data, eb_wr_en
   );

   modport slave (
      input  sym_in, sym_in_vld, fill_level, eb_full,
      output eb_data, eb_wr_en
   );
endinterface

// File: rtl/eb_os_tracker.sv
// SKP ordered-set tracker: follows COM/SKP framing and limits deletions per set.
module eb_os_tracker
   import eb_pkg::*;
#(
   parameter int MAX_DEL = DEF_MAX_DEL
) (
   input  logic         rclk,
   input  logic         rrst_n,
   input  logic         en,
   input  logic [9:0]   sym,
   input  logic         sym_vld,
   input  logic         del_take,
   output logic         deletable,
   output eb_os_state_t state,
   output eb_os_state_t next_state
);

   localparam logic [2:0] MAX_V = 3'(MAX_DEL);

   logic [2:0] del_os;

   always_comb begin
      next_state = state;
      if (!en) begin
         next_state = HUNT;
      end else if (sym_vld) begin
         if (sym == COM_SYM)
            next_state = COM;
         else if (sym == SKP_SYM && state != HUNT)
            next_state = SKP_RUN;
         else
            next_state = HUNT;
      end
   end

   // A SKP only counts as removable inside a set and while this set still has quota.
   assign deletable = en && sym_vld && (sym == SKP_SYM) && (state != HUNT) && (del_os < MAX_V);

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state  <= HUNT;
         del_os <= '0;
      end else begin
         state <= next_state;
         if (!en || (sym_vld && sym == COM_SYM))
            del_os <= '0;
         else if (del_take)
            del_os <= del_os + 3'd1;
      end
   end

endmodule

// File: rtl/eb_wr_ctrl.sv
// Elastic-buffer write controller: SKP deletion, write gating and overflow flagging.
// Optional ordered-set statistics (os_cnt, max_run) under EB_WR_CTRL_OS_STATS_EN.
module eb_wr_ctrl
   import eb_pkg::*;
#(
   parameter int ADDR_W     = 4,
   parameter int DEL_THRESH = DEF_DEL_THRESH,
   parameter int MAX_DEL    = DEF_MAX_DEL,
   parameter int CNT_W      = 16
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic             en,
   input  logic             cnt_clr,
   eb_wr_ctrl_if.slave      bus,
   output logic             skp_del,
   output logic             overflow_err,
   output logic [CNT_W-1:0] del_cnt
`ifdef EB_WR_CTRL_OS_STATS_EN
   ,
   output logic [CNT_W-1:0] os_cnt,
   output logic [3:0]       max_run
`endif
);

   localparam logic [ADDR_W:0] THRESH_V = (ADDR_W+1)'(DEL_THRESH);

   logic         deletable;
   logic         pressure;
   logic         do_del;
   logic         do_write;
   logic         do_drop;
   eb_os_state_t state;
   eb_os_state_t next_state;

   eb_os_tracker #(
      .MAX_DEL (MAX_DEL)
   ) u_tracker (
      .rclk       (rclk),
      .rrst_n     (rrst_n),
      .en         (en),
      .sym        (bus.sym_in),
      .sym_vld    (bus.sym_in_vld),
      .del_take   (do_del),
      .deletable  (deletable),
      .state      (state),
      .next_state (next_state)
   );

   // A full buffer always justifies deleting, whatever fill_level says.
   assign pressure = (bus.fill_level > THRESH_V) || bus.eb_full;
   assign do_del   = deletable && pressure;
   assign do_write = bus.sym_in_vld && !do_del && !bus.eb_full;
   assign do_drop  = bus.sym_in_vld && !do_del && bus.eb_full;

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         bus.eb_data  <= '0;
         bus.eb_wr_en <= 1'b0;
         skp_del      <= 1'b0;
         overflow_err <= 1'b0;
         del_cnt      <= '0;
      end else begin
         bus.eb_wr_en <= do_write;
         skp_del      <= do_del;
         overflow_err <= do_drop;
         if (do_write)
            bus.eb_data <= bus.sym_in;
         if (cnt_clr)
            del_cnt <= do_del ? CNT_W'(1) : '0;
         else if (do_del && del_cnt != '1)
            del_cnt <= del_cnt + CNT_W'(1);
      end
   end

`ifdef EB_WR_CTRL_OS_STATS_EN
   logic [3:0] cur_run;
   logic [3:0] run_next;
   logic       os_done;

   assign os_done = en && bus.sym_in_vld && (state == SKP_RUN) && (next_state != SKP_RUN);

   always_comb begin
      run_next = cur_run;
      if (!en)
         run_next = '0;
      else if (bus.sym_in_vld)
         run_next = (next_state == SKP_RUN) ? ((cur_run == 4'hF) ? cur_run : cur_run + 4'd1) : 4'd0;
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         cur_run <= '0;
         max_run <= '0;
         os_cnt  <= '0;
      end else begin
         cur_run <= run_next;
         if (cnt_clr) begin
            max_run <= '0;
            os_cnt  <= '0;
         end else begin
            if (run_next > max_run)
               max_run <= run_next;
            if (os_done && os_cnt != '1)
               os_cnt <= os_cnt + CNT_W'(1);
         end
      end
   end
`else
   logic unused_state;
   assign unused_state = ^{state, next_state};
`endif

endmodule
